// File: rtl/uart_tx_sched.sv
// Buffers CPU store bytes in a FIFO and issues one uart_wr strobe per byte,
// spaced by a fixed frame time so the serializer is never overrun.
module uart_tx_sched #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int BYTE_CYCLES = 8680
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic              uart_wr,
  output logic [7:0]        uart_dat
);

  localparam int GAP_W = $clog2(BYTE_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(BYTE_CYCLES - 2);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [GAP_W-1:0]  gap_q;
  state_e            state_q;
  logic              ovf_q, ovf_d;
  logic              uart_wr_q;
  logic [7:0]        uart_dat_q;
  logic              push, pop, full_w;

  // Full is judged on the pre-edge count, so a pop in the same cycle cannot rescue a push.
  always_comb begin
    full_w = (count_q == DEPTH_C);
    push   = wr_en && !full_w;
    pop    = (count_q != '0) &&
             ((state_q == IDLE) || ((state_q == GAP) && (gap_q == '0)));
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_en && full_w) ovf_d = 1'b1;
    else if (clr_ovf)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      state_q    <= IDLE;
      ovf_q      <= 1'b0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= 8'h00;
    end else begin
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      uart_wr_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        uart_dat_q <= mem[rd_ptr_q];
      end
      case (state_q)
        IDLE: begin
          if (pop) state_q <= ISSUE;
        end
        ISSUE: begin
          state_q <= GAP;
          gap_q   <= GAP_LOAD;
        end
        GAP: begin
          if (gap_q == '0) state_q <= pop ? ISSUE : IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full     = full_w;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign overflow = ovf_q;
  assign uart_wr  = uart_wr_q;
  assign uart_dat = uart_dat_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table vectors, directed corner
// sequences and random traffic against a time-slot queue model.
module tb_uart_tx_sched;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int BC = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_ovf = 1'b0;
  logic              full, empty, busy, overflow, uart_wr;
  logic [ADDR_W:0]   count;
  logic [7:0]        uart_dat;

  uart_tx_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTE_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow),
    .uart_wr(uart_wr), .uart_dat(uart_dat)
  );

  always #5 clk = ~clk;

  // Model: a byte queue plus the earliest edge at which the next byte may be sent.
  logic [7:0] mq[$];
  int         cyc = 0;
  int         next_ok = 0;
  bit         m_ovf = 1'b0;
  bit         m_wr = 1'b0;
  logic [7:0] m_dat = 8'h00;

  int         stb_cyc[$];
  logic [7:0] stb_dat[$];
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         c;
    bit         e_wr;
    logic [7:0] e_dat;
    int         e_cnt;
    bit         e_busy;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    next_ok = 0;
    m_ovf = 1'b0;
    m_wr = 1'b0;
    m_dat = 8'h00;
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit c);
    bit full_pre;
    wr_en = w;
    wr_data = d;
    clr_ovf = c;
    @(posedge clk);
    cyc++;
    full_pre = (mq.size() == DEPTH);
    m_wr = 1'b0;
    if (mq.size() != 0 && cyc >= next_ok) begin
      m_dat = mq.pop_front();
      m_wr = 1'b1;
      next_ok = cyc + BC;
    end
    if (w && full_pre) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    if (w && !full_pre) mq.push_back(d);
    #1;
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    chk("uart_wr", int'(uart_wr), int'(m_wr));
    chk("uart_dat", int'(uart_dat), int'(m_dat));
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("busy", int'(busy), int'(mq.size() != 0 || cyc < next_ok));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (uart_wr) begin
      stb_cyc.push_back(cyc);
      stb_dat.push_back(uart_dat);
      $display("strobe cyc=%0d data=%02h count=%0d", cyc, uart_dat, count);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    stb_cyc.delete();
    stb_dat.delete();
  endtask

  initial begin
    int n, busy_cycles, rate;

    tbl[0] = '{w:1'b1, d:8'h48, c:1'b0, e_wr:1'b0, e_dat:8'h00, e_cnt:1, e_busy:1'b1};
    tbl[1] = '{w:1'b1, d:8'h69, c:1'b0, e_wr:1'b1, e_dat:8'h48, e_cnt:1, e_busy:1'b1};
    tbl[2] = '{w:1'b1, d:8'h0A, c:1'b0, e_wr:1'b0, e_dat:8'h48, e_cnt:2, e_busy:1'b1};
    tbl[3] = '{w:1'b0, d:8'h00, c:1'b0, e_wr:1'b0, e_dat:8'h48, e_cnt:2, e_busy:1'b1};

    // Reset then idle
    do_reset();
    chk("rst_empty", int'(empty), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b0);
    chk("idle_strobes", stb_cyc.size(), 0);

    // Single push into idle
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_wr", int'(uart_wr), 1);
    chk("single_dat", int'(uart_dat), 8'h41);
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (busy) busy_cycles++;
    end
    chk("single_gap_cycles", busy_cycles, BC - 1);

    // Back-to-back pushes from the vector table
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].c);
      chk("tbl_wr", int'(uart_wr), int'(tbl[i].e_wr));
      chk("tbl_dat", int'(uart_dat), int'(tbl[i].e_dat));
      chk("tbl_count", int'(count), tbl[i].e_cnt);
      chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
    end
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00, 1'b0);
    chk("b2b_strobes", stb_cyc.size(), 3);
    if (stb_cyc.size() == 3) begin
      chk("b2b_space1", stb_cyc[1] - stb_cyc[0], BC);
      chk("b2b_space2", stb_cyc[2] - stb_cyc[1], BC);
      chk("b2b_d0", int'(stb_dat[0]), 8'h48);
      chk("b2b_d1", int'(stb_dat[1]), 8'h69);
      chk("b2b_d2", int'(stb_dat[2]), 8'h0A);
    end

    // Overfill: 18 pushes in 18 cycles
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 16) chk("fill_full", int'(full), 1);
    end
    chk("fill_ovf", int'(overflow), 1);
    for (int i = 0; i < 17 * BC + 10; i++) step(1'b0, 8'h00, 1'b0);
    chk("fill_strobes", stb_cyc.size(), 17);
    n = (stb_dat.size() < 17) ? stb_dat.size() : 17;
    for (int i = 0; i < n; i++) chk("fill_order", int'(stb_dat[i]), 8'h10 + i);
    step(1'b0, 8'h00, 1'b1);
    chk("clr_ovf", int'(overflow), 0);

    // Push on the edge where a full FIFO pops
    do_reset();
    step(1'b1, 8'hA0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 100 && !(mq.size() != 0 && cyc + 1 >= next_ok); i++)
      step(1'b0, 8'h00, 1'b0);
    chk("edge_full_before", int'(full), 1);
    step(1'b1, 8'hEE, 1'b0);
    chk("edge_count", int'(count), 15);
    chk("edge_ovf", int'(overflow), 1);
    chk("edge_wr", int'(uart_wr), 1);

    // Reset mid-GAP with 5 bytes queued
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", int'(count), 5);
    #2 rst = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_busy", int'(busy), 0);
    chk("async_wr", int'(uart_wr), 0);
    chk("async_dat", int'(uart_dat), 0);
    chk("async_full", int'(full), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    stb_cyc.delete();
    stb_dat.delete();
    for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0);
    chk("post_rst_strobes", stb_cyc.size(), 0);
    step(1'b1, 8'h55, 1'b0);
    chk("post_rst_first_wr", int'(uart_wr), 0);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_wr", int'(uart_wr), 1);
    chk("post_rst_dat", int'(uart_dat), 8'h55);

    // Random traffic with varying push rates
    do_reset();
    for (int p = 0; p < 8; p++) begin
      case (p % 4)
        0: rate = 5;
        1: rate = 60;
        2: rate = 100;
        default: rate = 15;
      endcase
      for (int i = 0; i < 250; i++)
        step(($urandom_range(0, 99) < rate), 8'($urandom), ($urandom_range(0, 99) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
